// File: rtl/axi_read_pkg.sv
// Shared types and helpers for the AXI4 read burst slave.
// Burst/response encodings, FSM states and the per-beat address step.
package axi_read_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Computed at a fixed wide width; callers truncate to their AW (modulo 2^AW).
    localparam int unsigned ADDR_MAX = 64;

    function automatic logic [ADDR_MAX-1:0] next_addr(
        input logic [ADDR_MAX-1:0] addr,
        input logic [2:0]          size,
        input logic [7:0]          len,
        input burst_t              burst
    );
        logic [ADDR_MAX-1:0] incr;
        logic [ADDR_MAX-1:0] mask;
        incr = ADDR_MAX'(1) << size;
        mask = ((ADDR_MAX'(len) + ADDR_MAX'(1)) << size) - ADDR_MAX'(1);
        case (burst)
            INCR:    next_addr = (addr & ~(incr - ADDR_MAX'(1))) + incr;
            WRAP:    next_addr = (addr & ~mask) | ((addr + incr) & mask);
            default: next_addr = addr;
        endcase
    endfunction

endpackage

// File: rtl/axi_read_burst_slave_fifo.sv
// Synchronous FIFO for queued read-address requests.
// Full/empty are registered; wr_ready stays low through reset.
module axi_ar_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_data,
    input  logic         wr_en,
    output logic         wr_ready,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_nxt;
    logic          push, pop;

    assign push    = wr_en && wr_ready;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + (PW+1)'(1);
        else if (pop && !push)
            count_nxt = count - (PW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            wr_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            wr_ready <= (count_nxt != (PW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/axi_read_burst_slave.sv
// AXI4 read slave: queues AR requests, expands bursts into backend beat
// requests and returns in-order R beats.
module axi_read_burst_slave
    import axi_read_pkg::*;
#(
    parameter int unsigned IDW      = 12,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 64,
    parameter int unsigned AR_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDW-1:0] s_arid,
    input  logic [AW-1:0]  s_araddr,
    input  logic [7:0]     s_arlen,
    input  logic [2:0]     s_arsize,
    input  logic [1:0]     s_arburst,
    input  logic           s_arvalid,
    output logic           s_arready,
    output logic [IDW-1:0] s_rid,
    output logic [DW-1:0]  s_rdata,
    output logic [1:0]     s_rresp,
    output logic           s_rlast,
    output logic           s_rvalid,
    input  logic           s_rready,
    output logic [AW-1:0]  be_req_addr,
    output logic [2:0]     be_req_size,
    output logic           be_req_valid,
    input  logic           be_req_ready,
    input  logic [DW-1:0]  be_rsp_data,
    input  logic           be_rsp_err,
    input  logic           be_rsp_valid,
    output logic           be_rsp_ready,
    output logic           busy
);

    localparam int unsigned SZ_MAX = $clog2(DW / 8);
    localparam int unsigned QW     = IDW + AW + 8 + 3 + 2;

    logic [QW-1:0]  q_wdata, q_rdata;
    logic           q_empty, q_pop;
    logic [IDW-1:0] h_id;
    logic [AW-1:0]  h_addr;
    logic [7:0]     h_len;
    logic [2:0]     h_size;
    logic [1:0]     h_burst;
    logic           h_err;

    state_t         state, state_nxt;
    logic [IDW-1:0] id_q;
    logic [AW-1:0]  addr_q;
    logic [7:0]     len_q, cnt_q;
    logic [2:0]     size_q;
    burst_t         burst_q;
    logic           err_q;
    logic [DW-1:0]  rdata_q;
    logic [1:0]     rresp_q;
    logic           last;

    assign q_wdata = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst};
    assign {h_id, h_addr, h_len, h_size, h_burst} = q_rdata;

    axi_ar_fifo #(
        .W     (QW),
        .DEPTH (AR_DEPTH)
    ) u_ar_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (q_wdata),
        .wr_en    (s_arvalid),
        .wr_ready (s_arready),
        .rd_en    (q_pop),
        .rd_data  (q_rdata),
        .empty    (q_empty)
    );

    always_comb begin
        h_err = 1'b0;
        if (h_burst == RSVD)
            h_err = 1'b1;
        if (h_size > 3'(SZ_MAX))
            h_err = 1'b1;
        if (h_burst == WRAP && !(h_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            h_err = 1'b1;
    end

    assign last        = (cnt_q == len_q);
    assign s_rid       = id_q;
    assign s_rdata     = rdata_q;
    assign s_rresp     = rresp_q;
    assign be_req_addr = addr_q;
    assign be_req_size = size_q;
    assign busy        = !q_empty || (state != IDLE);

    always_comb begin
        state_nxt    = state;
        q_pop        = 1'b0;
        s_rvalid     = 1'b0;
        s_rlast      = 1'b0;
        be_req_valid = 1'b0;
        be_rsp_ready = 1'b0;
        case (state)
            IDLE: if (!q_empty) begin
                q_pop     = 1'b1;
                state_nxt = h_err ? RESP : REQ;
            end
            REQ: begin
                be_req_valid = 1'b1;
                if (be_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                be_rsp_ready = 1'b1;
                if (be_rsp_valid) state_nxt = RESP;
            end
            RESP: begin
                s_rvalid = 1'b1;
                s_rlast  = last;
                // Error bursts never touch the backend: beats are produced back to back.
                if (s_rready)
                    state_nxt = last ? IDLE : (err_q ? RESP : REQ);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= FIXED;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (!q_empty) begin
                    id_q    <= h_id;
                    addr_q  <= h_addr;
                    len_q   <= h_len;
                    size_q  <= h_size;
                    burst_q <= burst_t'(h_burst);
                    err_q   <= h_err;
                    cnt_q   <= '0;
                    rdata_q <= '0;
                    rresp_q <= h_err ? SLVERR : OKAY;
                end
                WAIT: if (be_rsp_valid) begin
                    rdata_q <= be_rsp_data;
                    rresp_q <= be_rsp_err ? SLVERR : OKAY;
                end
                RESP: if (s_rready && !last) begin
                    cnt_q  <= cnt_q + 8'd1;
                    addr_q <= AW'(next_addr(ADDR_MAX'(addr_q), size_q, len_q, burst_q));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_burst_slave.sv
// Directed bench for axi_read_burst_slave: table of bursts with hand-computed
// beat addresses, plus sequences for back-pressure, queue-full and reset.
module tb_axi_read_burst_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] s_arid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [11:0] s_rid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] be_req_addr;
    logic [2:0]  be_req_size;
    logic        be_req_valid;
    logic        be_req_ready;
    logic [63:0] be_rsp_data;
    logic        be_rsp_err;
    logic        be_rsp_valid;
    logic        be_rsp_ready;
    logic        busy;

    axi_read_burst_slave #(
        .IDW      (12),
        .AW       (32),
        .DW       (64),
        .AR_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_arid       (s_arid),
        .s_araddr     (s_araddr),
        .s_arlen      (s_arlen),
        .s_arsize     (s_arsize),
        .s_arburst    (s_arburst),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_rid        (s_rid),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rlast      (s_rlast),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .be_req_addr  (be_req_addr),
        .be_req_size  (be_req_size),
        .be_req_valid (be_req_valid),
        .be_req_ready (be_req_ready),
        .be_rsp_data  (be_rsp_data),
        .be_rsp_err   (be_rsp_err),
        .be_rsp_valid (be_rsp_valid),
        .be_rsp_ready (be_rsp_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        err;
        int          err_beat;
        logic [31:0] exp_addr [4];
    } vec_t;

    typedef struct {
        logic [11:0] id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
    } req_t;

    vec_t  vecs [$];
    beat_t r_q [$];
    req_t  req_q [$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    err_beat = -1;
    int    rsp_cnt  = 0;

    function automatic logic [63:0] mkdata(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input logic err,
                       input int eb, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] a3);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.err = err; v.err_beat = eb;
        v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
        vecs.push_back(v);
    endtask

    // Backend: always ready for requests, answers in the first WAIT cycle.
    logic [31:0] last_req = '0;
    initial begin
        be_rsp_valid = 1'b0;
        be_rsp_data  = '0;
        be_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            be_rsp_valid = 1'b0;
            be_rsp_err   = 1'b0;
            if (!rst) begin
                if (be_req_valid && be_req_ready) begin
                    req_t r;
                    r.addr = be_req_addr;
                    r.size = be_req_size;
                    req_q.push_back(r);
                    last_req = be_req_addr;
                end
                if (be_rsp_ready) begin
                    be_rsp_valid = 1'b1;
                    be_rsp_data  = mkdata(last_req);
                    be_rsp_err   = (rsp_cnt == err_beat);
                    rsp_cnt++;
                end
            end
        end
    end

    // R monitor: logs accepted beats and checks outputs hold while stalled.
    logic  prev_stall = 1'b0;
    beat_t saved;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall rvalid", s_rvalid, 1);
                    chk("stall rdata", s_rdata, saved.data);
                    chk("stall rlast", s_rlast, saved.last);
                    chk("stall rid", s_rid, saved.id);
                    chk("stall be_req_valid", be_req_valid, 0);
                end
                saved.id = s_rid; saved.data = s_rdata; saved.resp = s_rresp; saved.last = s_rlast;
                prev_stall = s_rvalid && !s_rready;
                if (s_rvalid && s_rready) r_q.push_back(saved);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        while (!s_arready && n < 200) begin cyc(); n++; end
        if (n >= 200) chk("ar handshake timeout", 0, 1);
        cyc();
        s_arvalid = 1'b0;
    endtask

    task automatic wait_beats(input int nb);
        int n = 0;
        while (r_q.size() < nb && n < 500) begin cyc(); n++; end
        if (n >= 500) chk("beat wait timeout", r_q.size(), nb);
    endtask

    task automatic clear();
        r_q.delete();
        req_q.delete();
        rsp_cnt = 0;
    endtask

    task automatic check_vec(input vec_t v);
        int nb = int'(v.len) + 1;
        int nr = v.err ? 0 : nb;
        chk($sformatf("req count id%0d", v.id), req_q.size(), nr);
        chk($sformatf("beat count id%0d", v.id), r_q.size(), nb);
        for (int i = 0; i < nr && i < req_q.size(); i++) begin
            chk($sformatf("req addr id%0d b%0d", v.id, i), req_q[i].addr, v.exp_addr[i]);
            chk($sformatf("req size id%0d b%0d", v.id, i), req_q[i].size, v.size);
        end
        for (int i = 0; i < nb && i < r_q.size(); i++) begin
            chk($sformatf("rid id%0d b%0d", v.id, i), r_q[i].id, v.id);
            chk($sformatf("rdata id%0d b%0d", v.id, i), r_q[i].data,
                v.err ? 64'h0 : mkdata(v.exp_addr[i]));
            chk($sformatf("rresp id%0d b%0d", v.id, i), r_q[i].resp,
                (v.err || i == v.err_beat) ? 2'b10 : 2'b00);
            chk($sformatf("rlast id%0d b%0d", v.id, i), r_q[i].last, i == nb - 1);
        end
    endtask

    task automatic run_vec(input vec_t v);
        clear();
        err_beat = v.err_beat;
        send_ar(v.id, v.addr, v.len, v.size, v.burst);
        wait_beats(int'(v.len) + 1);
        repeat (6) cyc();
        check_vec(v);
        err_beat = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //   id      addr           len   sz    burst  err   eb   expected beat addresses
        add(12'd5,  32'h0000_0100, 8'd3, 3'd3, 2'b01, 1'b0, -1, 32'h100, 32'h108, 32'h110, 32'h118);
        add(12'd6,  32'h0000_0038, 8'd3, 3'd3, 2'b10, 1'b0, -1, 32'h38,  32'h20,  32'h28,  32'h30);
        add(12'd7,  32'h0000_0040, 8'd2, 3'd3, 2'b00, 1'b0, -1, 32'h40,  32'h40,  32'h40,  32'h0);
        add(12'd8,  32'h0000_0000, 8'd1, 3'd3, 2'b11, 1'b1, -1, 32'h0,   32'h0,   32'h0,   32'h0);
        add(12'd9,  32'h0000_0103, 8'd2, 3'd2, 2'b01, 1'b0, -1, 32'h103, 32'h104, 32'h108, 32'h0);
        add(12'd10, 32'h0000_0000, 8'd2, 3'd3, 2'b10, 1'b1, -1, 32'h0,   32'h0,   32'h0,   32'h0);
        add(12'd11, 32'h0000_0000, 8'd0, 3'd4, 2'b01, 1'b1, -1, 32'h0,   32'h0,   32'h0,   32'h0);
        add(12'd12, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 1'b0, -1, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0);
        add(12'd13, 32'h0000_0014, 8'd1, 3'd2, 2'b10, 1'b0, -1, 32'h14,  32'h10,  32'h0,   32'h0);
        add(12'd14, 32'h0000_0300, 8'd3, 3'd3, 2'b01, 1'b0,  1, 32'h300, 32'h308, 32'h310, 32'h318);

        rst = 1'b1;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_arvalid = 1'b0; s_rready = 1'b1; be_req_ready = 1'b1;
        repeat (3) cyc();
        chk("reset arready", s_arready, 0);
        chk("reset rvalid", s_rvalid, 0);
        chk("reset rlast/rresp/rid", {s_rlast, s_rresp, s_rid}, 0);
        chk("reset rdata", s_rdata, 0);
        chk("reset be valid/ready", {be_req_valid, be_rsp_ready}, 0);
        chk("reset busy", busy, 0);
        rst = 1'b0;
        cyc();
        chk("arready after reset", s_arready, 1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Back-pressure: stall R on beat 2 for several cycles.
        begin
            int n = 0;
            add(12'd15, 32'h0000_0200, 8'd3, 3'd3, 2'b01, 1'b0, -1, 32'h200, 32'h208, 32'h210, 32'h218);
            v = vecs[vecs.size() - 1];
            clear();
            send_ar(v.id, v.addr, v.len, v.size, v.burst);
            while (r_q.size() < 1 && n < 100) begin cyc(); n++; end
            s_rready = 1'b0;
            n = 0;
            while (!s_rvalid && n < 100) begin cyc(); n++; end
            repeat (5) cyc();
            chk("bp rvalid held", s_rvalid, 1);
            chk("bp rdata beat2", s_rdata, mkdata(32'h208));
            chk("bp rlast beat2", s_rlast, 0);
            chk("bp beats so far", r_q.size(), 1);
            s_rready = 1'b1;
            wait_beats(4);
            repeat (6) cyc();
            check_vec(v);
        end

        // Queue full: stall R so 1 burst is in flight and 4 sit in the queue.
        begin
            int n = 0;
            clear();
            s_rready = 1'b0;
            for (int k = 0; k < 5; k++)
                send_ar(12'(20 + k), 32'h600 + 32'(k * 16), 8'd0, 3'd3, 2'b01);
            chk("ar full after 4 queued", s_arready, 0);
            s_arid = 12'd25; s_araddr = 32'h650; s_arlen = 8'd0; s_arsize = 3'd3;
            s_arburst = 2'b01; s_arvalid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                cyc();
                chk("ar held while full", s_arready, 0);
            end
            chk("busy while full", busy, 1);
            s_rready = 1'b1;
            while (!s_arready && n < 100) begin cyc(); n++; end
            chk("6th ar accepted", s_arready, 1);
            cyc();
            s_arvalid = 1'b0;
            wait_beats(6);
            repeat (6) cyc();
            chk("full beat count", r_q.size(), 6);
            for (int k = 0; k < 6 && k < r_q.size(); k++) begin
                chk($sformatf("order rid %0d", k), r_q[k].id, 12'(20 + k));
                chk($sformatf("order rdata %0d", k), r_q[k].data, mkdata(32'h600 + 32'(k * 16)));
                chk($sformatf("order rlast %0d", k), r_q[k].last, 1);
            end
        end

        // Reset during RESP of beat 2 with another request queued.
        begin
            int n = 0;
            clear();
            send_ar(12'd30, 32'h400, 8'd3, 3'd3, 2'b01);
            send_ar(12'd31, 32'h480, 8'd1, 3'd3, 2'b01);
            while (r_q.size() < 1 && n < 100) begin cyc(); n++; end
            s_rready = 1'b0;
            n = 0;
            while (!s_rvalid && n < 100) begin cyc(); n++; end
            @(posedge clk);
            #3;
            rst = 1'b1;
            #1;
            chk("async rst rvalid", s_rvalid, 0);
            chk("async rst arready", s_arready, 0);
            chk("async rst busy", busy, 0);
            chk("async rst be_req_valid", be_req_valid, 0);
            cyc();
            s_rready = 1'b1;
            repeat (2) cyc();
            rst = 1'b0;
            clear();
            cyc();
            chk("arready after mid reset", s_arready, 1);
            chk("queue empty after reset", busy, 0);
            add(12'd3, 32'h0000_0500, 8'd1, 3'd3, 2'b01, 1'b0, -1, 32'h500, 32'h508, 32'h0, 32'h0);
            run_vec(vecs[vecs.size() - 1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
